shift_register_burst: RTL and testbench

- Parametrised universal shift register: WIDTH bits, eight operating modes including rotate, arithmetic shift and synchronous clear.
- Burst engine performs a programmed number of shifts or rotates autonomously, reporting busy and a done pulse.
- Serves as the general-purpose shifter for serialiser, LFSR-seeding and bit-banging datapaths; mode encodings 0-3 keep the team's existing 4-bit shift register select encoding.

---
 rtl/shift_register_burst.sv | 110 +++++++++++
 tb/tb_shift_register_burst.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_burst.sv
// Universal shift register with eight modes and an autonomous burst engine
// that repeats a shift/rotate op for a programmed number of cycles.
module shift_register_burst #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic [WIDTH-1:0] p_din,
   input  logic             s_left_din,
   input  logic             s_right_din,
   output logic [WIDTH-1:0] p_dout,
   output logic             s_left_dout,
   output logic             s_right_dout,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] OP_HOLD = 3'd0;
   localparam logic [2:0] OP_SHR  = 3'd1;
   localparam logic [2:0] OP_SHL  = 3'd2;
   localparam logic [2:0] OP_LOAD = 3'd3;
   localparam logic [2:0] OP_ROR  = 3'd4;
   localparam logic [2:0] OP_ROL  = 3'd5;
   localparam logic [2:0] OP_ASR  = 3'd6;
   localparam logic [2:0] OP_CLR  = 3'd7;

   localparam logic S_IDLE  = 1'b0;
   localparam logic S_BURST = 1'b1;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   logic             state;
   logic [CNT_W-1:0] remaining;
   logic [2:0]       burst_mode;
   logic [WIDTH-1:0] q;

   logic [2:0]       op_sel;
   logic [WIDTH-1:0] q_next;
   logic             mode_burstable;
   logic             accept;

   assign mode_burstable = (mode == OP_SHR) || (mode == OP_SHL) ||
                           (mode == OP_ROR) || (mode == OP_ROL) ||
                           (mode == OP_ASR);

   assign accept = (state == S_IDLE) && start &&
                   (count != CNT_ZERO) && mode_burstable;

   // In BURST the latched mode drives the datapath; live mode is ignored.
   assign op_sel = (state == S_BURST) ? burst_mode : mode;

   always_comb begin
      q_next = q;
      case (op_sel)
         OP_HOLD: q_next = q;
         OP_SHR:  q_next = {s_right_din, q[WIDTH-1:1]};
         OP_SHL:  q_next = {q[WIDTH-2:0], s_left_din};
         OP_LOAD: q_next = p_din;
         OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
         OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
         OP_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
         OP_CLR:  q_next = '0;
         default: q_next = q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q          <= '0;
         state      <= S_IDLE;
         remaining  <= '0;
         burst_mode <= OP_HOLD;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (en) begin
            q <= q_next;
            if (state == S_BURST) begin
               if (remaining != CNT_ZERO) begin
                  remaining <= remaining - CNT_ONE;
               end
               if (remaining <= CNT_ONE) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end
            end else if (accept) begin
               burst_mode <= mode;
               remaining  <= count - CNT_ONE;
               if (count == CNT_ONE) begin
                  done <= 1'b1;
               end else begin
                  state <= S_BURST;
               end
            end
         end
      end
   end

   assign p_dout       = q;
   assign s_left_dout  = q[0];
   assign s_right_dout = q[WIDTH-1];
   assign busy         = (state == S_BURST);

endmodule

// File: tb/tb_shift_register_burst.sv
// Directed and randomized checks of shift_register_burst against an
// arithmetic reference model of the shift/burst behaviour.
module tb_shift_register_burst;

   localparam int W  = 8;
   localparam int CW = 4;
   localparam int MASK = (1 << W) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [2:0]    mode;
   logic          start;
   logic [CW-1:0] count;
   logic [W-1:0]  p_din;
   logic          s_left_din;
   logic          s_right_din;
   logic [W-1:0]  p_dout;
   logic          s_left_dout;
   logic          s_right_dout;
   logic          busy;
   logic          done;

   int errors = 0;
   int checks = 0;

   int m_q;
   int m_left;
   int m_bmode;
   bit m_done;

   shift_register_burst #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .mode(mode),
      .start(start),
      .count(count),
      .p_din(p_din),
      .s_left_din(s_left_din),
      .s_right_din(s_right_din),
      .p_dout(p_dout),
      .s_left_dout(s_left_dout),
      .s_right_dout(s_right_dout),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int apply(int op, int q);
      case (op)
         1: return (q >> 1) | (int'(s_right_din) << (W - 1));
         2: return ((q << 1) | int'(s_left_din)) & MASK;
         3: return int'(p_din);
         4: return (q >> 1) | ((q % 2) << (W - 1));
         5: return ((q << 1) & MASK) | (q >> (W - 1));
         6: return (q >> 1) | (q & (1 << (W - 1)));
         7: return 0;
         default: return q;
      endcase
   endfunction

   function automatic bit burstable(int op);
      return op == 1 || op == 2 || op == 4 || op == 5 || op == 6;
   endfunction

   task automatic model_reset();
      m_q = 0;
      m_left = 0;
      m_bmode = 0;
      m_done = 0;
   endtask

   task automatic check_all(string tag);
      check({tag, ".q"}, p_dout, W'(m_q));
      check({tag, ".sl"}, W'(s_left_dout), W'(m_q % 2));
      check({tag, ".sr"}, W'(s_right_dout), W'(m_q >> (W - 1)));
      check({tag, ".busy"}, W'(busy), W'(m_left > 0));
      check({tag, ".done"}, W'(done), W'(m_done));
   endtask

   // Model advances with the inputs as they stand just before the edge.
   task automatic tick(string tag = "step");
      bit nd;
      nd = 0;
      if (en) begin
         if (m_left > 0) begin
            m_q = apply(m_bmode, m_q);
            m_left--;
            if (m_left == 0) nd = 1;
         end else if (start && count != 0 && burstable(int'(mode))) begin
            m_q = apply(int'(mode), m_q);
            m_bmode = int'(mode);
            m_left = int'(count) - 1;
            if (m_left == 0) nd = 1;
         end else begin
            m_q = apply(int'(mode), m_q);
         end
      end
      m_done = nd;
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic async_reset();
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      rst = 1'b0;
   endtask

   task automatic load(logic [W-1:0] v);
      mode = 3'd3;
      p_din = v;
      start = 1'b0;
      tick("load");
   endtask

   initial begin
      rst = 1'b1;
      en = 1'b1;
      mode = 3'd0;
      start = 1'b0;
      count = '0;
      p_din = '0;
      s_left_din = 1'b0;
      s_right_din = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      rst = 1'b0;

      load(8'hA5);
      check("load_a5", p_dout, 8'hA5);
      check("load_a5_sl", W'(s_left_dout), 8'h01);
      check("load_a5_sr", W'(s_right_dout), 8'h01);
      mode = 3'd1; s_right_din = 1'b1; tick("shr");
      check("shr", p_dout, 8'hD2);
      load(8'hA5);
      mode = 3'd2; s_left_din = 1'b0; tick("shl");
      check("shl", p_dout, 8'h4A);

      load(8'h81);
      mode = 3'd4; tick("ror");
      check("ror", p_dout, 8'hC0);
      load(8'h81);
      mode = 3'd5; tick("rol");
      check("rol", p_dout, 8'h03);
      load(8'h80);
      mode = 3'd6; tick("asr1");
      check("asr1", p_dout, 8'hC0);
      tick("asr2");
      check("asr2", p_dout, 8'hE0);
      mode = 3'd7; tick("clr");
      check("clr", p_dout, 8'h00);
      load(8'h5A);
      mode = 3'd0;
      repeat (5) tick("hold");
      check("hold", p_dout, 8'h5A);

      load(8'h01);
      mode = 3'd2; start = 1'b1; count = 4'd3; s_left_din = 1'b0;
      tick("b3_acc");
      start = 1'b0; mode = 3'd0;
      check("b3_acc", p_dout, 8'h02);
      check("b3_busy", W'(busy), 8'h01);
      tick("b3_2");
      check("b3_2", p_dout, 8'h04);
      tick("b3_3");
      check("b3_3", p_dout, 8'h08);
      check("b3_done", W'(done), 8'h01);
      check("b3_idle", W'(busy), 8'h00);
      tick("b3_after");
      check("b3_done_clr", W'(done), 8'h00);

      load(8'h01);
      mode = 3'd4; start = 1'b1; count = 4'd5;
      tick("b5_acc");
      mode = 3'd3; p_din = 8'hFF;
      tick("b5_2");
      en = 1'b0;
      repeat (3) tick("b5_frz");
      check("b5_frz", p_dout, 8'h40);
      check("b5_frz_busy", W'(busy), 8'h01);
      en = 1'b1;
      tick("b5_3");
      tick("b5_4");
      start = 1'b0; mode = 3'd0;
      tick("b5_5");
      check("b5_final", p_dout, 8'h08);
      check("b5_done", W'(done), 8'h01);
      tick("b5_after");

      mode = 3'd5; start = 1'b1; count = 4'd0;
      tick("cnt0");
      check("cnt0", p_dout, 8'h10);
      mode = 3'd3; p_din = 8'h3C; count = 4'd4;
      tick("start_load");
      check("start_load", p_dout, 8'h3C);
      start = 1'b0;

      mode = 3'd1; start = 1'b1; count = 4'd7; s_right_din = 1'b1;
      tick("b7_acc");
      start = 1'b0; mode = 3'd0;
      tick("b7_2");
      tick("b7_3");
      async_reset();
      check("rst_q", p_dout, 8'h00);
      check("rst_busy", W'(busy), 8'h00);
      tick("post_rst1");
      tick("post_rst2");
      load(8'h01);
      mode = 3'd5; start = 1'b1; count = 4'd2;
      tick("fresh_acc");
      start = 1'b0; mode = 3'd0;
      check("fresh_busy", W'(busy), 8'h01);
      tick("fresh_end");
      check("fresh_q", p_dout, 8'h04);
      check("fresh_done", W'(done), 8'h01);

      for (int i = 0; i < 600; i++) begin
         en = ($urandom_range(0, 7) != 0);
         mode = 3'($urandom);
         start = ($urandom_range(0, 3) == 0);
         count = CW'($urandom);
         p_din = W'($urandom);
         s_left_din = 1'($urandom);
         s_right_din = 1'($urandom);
         tick("rand");
         if ($urandom_range(0, 59) == 0) async_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
